// File: rtl/spi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_arb_pkg
// Description : Shared types and default timing constants for the SPI bus
//               arbiter: FSM state encoding and default chip-select
//               setup/hold and byte-watchdog cycle counts.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_CS_SETUP = 3'd2,
        ST_LOAD     = 3'd3,
        ST_XFER     = 3'd4,
        ST_CS_HOLD  = 3'd5
    } arb_state_t;

    localparam int unsigned C_DEF_CS_SETUP_CYC = 2;
    localparam int unsigned C_DEF_CS_HOLD_CYC  = 2;
    localparam int unsigned C_DEF_TIMEOUT_CYC  = 1024;

endpackage : spi_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Chooses the first requesting
//               index at or after the pointer, wrapping modulo NUM_REQ.
// Ports       : i_req       - request vector
//               i_ptr       - index with highest priority this pick
//               o_grant     - one-hot grant (zero when nothing requests)
//               o_grant_idx - binary index of the granted requester
//               o_valid     - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_valid
);

    // Each requester's priority is its forward distance from the pointer;
    // the smallest distance among active requesters wins.
    always_comb begin
        int w_dist;
        int w_best;
        o_grant     = '0;
        o_grant_idx = '0;
        o_valid     = 1'b0;
        w_dist      = 0;
        w_best      = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (k >= int'(i_ptr)) begin
                w_dist = k - int'(i_ptr);
            end else begin
                w_dist = k + int'(NUM_REQ) - int'(i_ptr);
            end
            if (i_req[k] && (!o_valid || (w_dist < w_best))) begin
                o_valid     = 1'b1;
                w_best      = w_dist;
                o_grant     = '0;
                o_grant[k]  = 1'b1;
                o_grant_idx = PTR_W'(k);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bus_arbiter
// Description : Shares one SPI master byte engine among NUM_REQ requesters.
//               Round-robin grant, chip-select setup/hold framing, one byte
//               handed to the master at a time, received bytes returned to
//               the granted requester.
// Options     : SPI_ARB_TIMEOUT_EN - enables the per-byte watchdog that
//               aborts a transfer after TIMEOUT_CYC cycles and pulses err_o.
// Ports       : sysClk/Rst_i_n        - clock, async active-low reset
//               req_i/last_i/tx_data_i - per-requester request and byte
//               grant_o/byte_ack_o/rx_data_o/busy_o/err_o - requester side
//               cs_n_o                 - slave chip select
//               m_tx_en_o/m_tx_byte_o/m_done_i/m_rx_byte_i - master engine
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bus_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned CS_SETUP_CYC = C_DEF_CS_SETUP_CYC,
    parameter int unsigned CS_HOLD_CYC  = C_DEF_CS_HOLD_CYC,
    parameter int unsigned TIMEOUT_CYC  = C_DEF_TIMEOUT_CYC
) (
    input  logic                 sysClk,
    input  logic                 Rst_i_n,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ-1:0]   last_i,
    input  logic [NUM_REQ*8-1:0] tx_data_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 byte_ack_o,
    output logic [7:0]           rx_data_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 cs_n_o,
    output logic                 m_tx_en_o,
    output logic [7:0]           m_tx_byte_o,
    input  logic                 m_done_i,
    input  logic [7:0]           m_rx_byte_i
);

    localparam int unsigned PTR_W   = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_gidx;
    logic [NUM_REQ-1:0] r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;
    logic               r_cs_n;
    logic               r_tx_en;
    logic [7:0]         r_tx_byte;
    logic               r_ack;
    logic [7:0]         r_rx;
    logic               r_err;

    logic [NUM_REQ-1:0] w_arb_grant;
    logic [PTR_W-1:0]   w_arb_idx;
    logic               w_arb_valid;
    logic               w_sel_req;
    logic               w_sel_last;
    logic [7:0]         w_sel_data;
    logic               w_setup_done;
    logic               w_hold_done;
    logic               w_timeout;
    logic               w_do_grant;
    logic               w_do_load;
    logic               w_do_ack;
    logic               w_do_err;
    logic               w_do_release;
    logic               w_busy;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req       (req_i),
        .i_ptr       (r_ptr),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx),
        .o_valid     (w_arb_valid)
    );

    // Signals of the currently granted requester
    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_last = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (r_gidx == PTR_W'(i)) begin
                w_sel_req  = req_i[i];
                w_sel_last = last_i[i];
                w_sel_data = tx_data_i[i*8 +: 8];
            end
        end
    end

    assign w_setup_done = (r_cnt == CNT_W'(CS_SETUP_CYC - 1));
    assign w_hold_done  = (r_cnt == CNT_W'(CS_HOLD_CYC - 1));

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wd;

    // Cleared outside XFER, so every byte starts its watchdog from zero
    always_ff @(posedge sysClk or negedge Rst_i_n) begin
        if (!Rst_i_n) begin
            r_wd <= '0;
        end else if (r_state != ST_XFER) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 1'b1;
        end
    end

    assign w_timeout = (r_wd == WD_W'(TIMEOUT_CYC - 1));
`else
    // Timeout limit has no consumer when the watchdog is absent
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign w_timeout        = 1'b0;
`endif

    // State register
    always_ff @(posedge sysClk or negedge Rst_i_n) begin
        if (!Rst_i_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (|req_i) w_state_nxt = ST_ARB;
            ST_ARB:      w_state_nxt = w_arb_valid ? ST_CS_SETUP : ST_IDLE;
            ST_CS_SETUP: if (w_setup_done) w_state_nxt = ST_LOAD;
            ST_LOAD:     w_state_nxt = w_sel_req ? ST_XFER : ST_CS_HOLD;
            ST_XFER: begin
                if (m_done_i) begin
                    w_state_nxt = r_last ? ST_CS_HOLD : ST_LOAD;
                end else if (w_timeout) begin
                    w_state_nxt = ST_CS_HOLD;
                end
            end
            ST_CS_HOLD:  if (w_hold_done) w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // Output / event decode
    always_comb begin
        w_do_grant   = (r_state == ST_ARB) && w_arb_valid;
        w_do_load    = (r_state == ST_LOAD) && w_sel_req;
        w_do_ack     = (r_state == ST_XFER) && m_done_i;
        w_do_err     = (r_state == ST_XFER) && !m_done_i && w_timeout;
        w_do_release = (r_state == ST_CS_HOLD) && w_hold_done;
        w_busy       = (r_state != ST_IDLE);
    end

    // Pointer, counters and datapath registers
    always_ff @(posedge sysClk or negedge Rst_i_n) begin
        if (!Rst_i_n) begin
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_last    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_tx_en   <= 1'b0;
            r_tx_byte <= '0;
            r_ack     <= 1'b0;
            r_rx      <= '0;
            r_err     <= 1'b0;
        end else begin
            r_tx_en <= w_do_load;
            r_ack   <= w_do_ack;
            r_err   <= w_do_err;

            // Phase counter restarts on every state change
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == ST_CS_SETUP) || (r_state == ST_CS_HOLD)) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_do_grant) begin
                r_grant <= w_arb_grant;
                r_gidx  <= w_arb_idx;
                r_ptr   <= (w_arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
                r_cs_n  <= 1'b0;
            end
            if (w_do_release) begin
                r_grant <= '0;
                r_cs_n  <= 1'b1;
            end
            if (w_do_load) begin
                r_tx_byte <= w_sel_data;
                r_last    <= w_sel_last;
            end
            if (w_do_ack) begin
                r_rx <= m_rx_byte_i;
            end
        end
    end

    assign grant_o     = r_grant;
    assign byte_ack_o  = r_ack;
    assign rx_data_o   = r_rx;
    assign busy_o      = w_busy;
    assign err_o       = r_err;
    assign cs_n_o      = r_cs_n;
    assign m_tx_en_o   = r_tx_en;
    assign m_tx_byte_o = r_tx_byte;

endmodule : spi_bus_arbiter
`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_bus_arbiter
// Description : Self-checking bench for spi_bus_arbiter. Requesters and the
//               SPI master are modelled at transaction level; expected
//               grants, bytes, latencies and chip-select lengths come from a
//               round-robin/timing model kept in the bench.
// Options     : SPI_ARB_TIMEOUT_EN - also exercises the byte watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_bus_arbiter;

    localparam int NUM_REQ = 2;
    localparam int SETUP   = 2;
    localparam int HOLD    = 2;
    localparam int TMO     = 16;

    logic                 sysClk = 1'b0;
    logic                 Rst_i_n;
    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ-1:0]   last_i;
    logic [NUM_REQ*8-1:0] tx_data_i;
    logic [NUM_REQ-1:0]   grant_o;
    logic                 byte_ack_o;
    logic [7:0]           rx_data_o;
    logic                 busy_o;
    logic                 err_o;
    logic                 cs_n_o;
    logic                 m_tx_en_o;
    logic [7:0]           m_tx_byte_o;
    logic                 m_done_i;
    logic [7:0]           m_rx_byte_i;

    spi_bus_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CS_SETUP_CYC (SETUP),
        .CS_HOLD_CYC  (HOLD),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .sysClk      (sysClk),
        .Rst_i_n     (Rst_i_n),
        .req_i       (req_i),
        .last_i      (last_i),
        .tx_data_i   (tx_data_i),
        .grant_o     (grant_o),
        .byte_ack_o  (byte_ack_o),
        .rx_data_o   (rx_data_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .cs_n_o      (cs_n_o),
        .m_tx_en_o   (m_tx_en_o),
        .m_tx_byte_o (m_tx_byte_o),
        .m_done_i    (m_done_i),
        .m_rx_byte_i (m_rx_byte_i)
    );

    always #5 sysClk = ~sysClk;

    int checks   = 0;
    int failures = 0;

    // Requester model state
    logic [7:0] txq [NUM_REQ][8];
    int         len    [NUM_REQ];
    int         stop   [NUM_REQ];
    int         idx    [NUM_REQ];
    bit         active [NUM_REQ];
    int         ptr_model;
    int         fixed_lat;
    int         fixed_rx;
    bit         no_resp;
    bit         start_chk;
    int         first_grant;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_i[i]             = active[i];
            tx_data_i[i*8 +: 8]  = txq[i][idx[i]];
            last_i[i]            = (idx[i] == len[i] - 1);
        end
    endtask

    task automatic prep(input int r, input int n, input int s);
        len[r]    = n;
        stop[r]   = s;
        idx[r]    = 0;
        active[r] = 1'b1;
        for (int k = 0; k < 8; k++) txq[r][k] = 8'($urandom);
    endtask

    task automatic do_reset();
        Rst_i_n     = 1'b0;
        m_done_i    = 1'b0;
        m_rx_byte_i = 8'h00;
        ptr_model   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            active[i] = 1'b0;
            idx[i]    = 0;
            len[i]    = 1;
            stop[i]   = 1;
        end
        drive_inputs();
        repeat (3) @(posedge sysClk);
        #1;
        check_val("rst_grant",   grant_o, 0);
        check_val("rst_cs_n",    cs_n_o, 1);
        check_val("rst_tx_en",   m_tx_en_o, 0);
        check_val("rst_tx_byte", m_tx_byte_o, 0);
        check_val("rst_ack",     byte_ack_o, 0);
        check_val("rst_rx",      rx_data_o, 0);
        check_val("rst_busy",    busy_o, 0);
        check_val("rst_err",     err_o, 0);
        @(negedge sysClk);
        Rst_i_n = 1'b1;
        @(posedge sysClk);
        #1;
    endtask

    // Runs until every active requester has finished and the bus is idle.
    task automatic run_round(input string name);
        int         cyc       = 0;
        int         g         = -1;
        int         cs_fall   = 0;
        int         exp_len   = 0;
        int         cd        = 0;
        int         done_cyc  = -100;
        int         tx_cyc    = -100;
        int         exp_tx    = -1;
        int         lat       = 0;
        int         e;
        bit         prev_cs   = 1'b1;
        bit         got_first = 1'b0;
        logic [7:0] last_rx   = 8'h00;
        first_grant = 0;
        drive_inputs();
        forever begin
            @(posedge sysClk);
            #1;
            cyc++;
            m_done_i    = 1'b0;
            m_rx_byte_i = 8'($urandom);

            if (!cs_n_o && prev_cs) begin
                e = -1;
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (e < 0 && active[(ptr_model + k) % NUM_REQ]) e = (ptr_model + k) % NUM_REQ;
                end
                if (e < 0) begin
                    check_val({name, ":spurious_grant"}, grant_o, 0);
                end else begin
                    check_val({name, ":grant"}, grant_o, 32'(1) << e);
                    ptr_model = (e + 1) % NUM_REQ;
                end
                if (!got_first) begin
                    first_grant = int'(grant_o);
                    got_first   = 1'b1;
                    if (start_chk) check_val({name, ":grant_latency"}, cyc, 2);
                end
                g       = e;
                cs_fall = cyc;
                exp_len = SETUP + HOLD;
            end

            if (byte_ack_o) begin
                if (g < 0) begin
                    check_val({name, ":ack_unexpected"}, 1, 0);
                end else begin
                    check_val({name, ":rx_data"}, rx_data_o, last_rx);
                    check_val({name, ":ack_latency"}, cyc, done_cyc + 1);
                    check_val({name, ":ack_grant"}, grant_o, 32'(1) << g);
                    idx[g]++;
                    if (idx[g] == stop[g]) begin
                        active[g] = 1'b0;
                        if (stop[g] < len[g]) exp_len += 1;
                    end else begin
                        exp_tx = cyc + 1;
                    end
                    drive_inputs();
                end
            end

            if (m_tx_en_o) begin
                if (g < 0 || idx[(g < 0) ? 0 : g] >= stop[(g < 0) ? 0 : g]) begin
                    check_val({name, ":tx_unexpected"}, 1, 0);
                end else begin
                    check_val({name, ":tx_byte"}, m_tx_byte_o, txq[g][idx[g]]);
                    if (exp_tx >= 0) check_val({name, ":tx_gap"}, cyc, exp_tx);
                end
                exp_tx = -1;
                tx_cyc = cyc;
                lat    = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 5));
                cd     = no_resp ? 0 : lat;
                exp_len += 1 + (no_resp ? TMO : lat);
            end

            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    last_rx     = (fixed_rx >= 0) ? 8'(fixed_rx) : 8'($urandom);
                    m_done_i    = 1'b1;
                    m_rx_byte_i = last_rx;
                    done_cyc    = cyc;
                end
            end

            if (err_o) begin
`ifdef SPI_ARB_TIMEOUT_EN
                check_val({name, ":err_latency"}, cyc - tx_cyc, TMO);
                check_val({name, ":err_no_ack"}, byte_ack_o, 0);
                if (g >= 0) begin
                    active[g] = 1'b0;
                    drive_inputs();
                end
`else
                check_val({name, ":err_without_watchdog"}, err_o, 0);
`endif
            end

            if (cs_n_o && !prev_cs) begin
                check_val({name, ":cs_low_len"}, cyc - cs_fall, exp_len);
                check_val({name, ":grant_clear"}, grant_o, 0);
                g = -1;
            end
            prev_cs = cs_n_o;

            if (!active[0] && !active[1] && !busy_o && cs_n_o) break;
            if (cyc > 3000) begin
                check_val({name, ":cycle_budget"}, cyc, 0);
                break;
            end
        end
    endtask

    initial begin
        logic [7:0] rx_hold;
        Rst_i_n     = 1'b0;
        req_i       = '0;
        last_i      = '0;
        tx_data_i   = '0;
        m_done_i    = 1'b0;
        m_rx_byte_i = 8'h00;
        fixed_lat   = 0;
        fixed_rx    = -1;
        no_resp     = 1'b0;
        start_chk   = 1'b0;
        do_reset();

        // Single one-byte transfer
        prep(0, 1, 1);
        txq[0][0] = 8'hA5;
        fixed_lat = 3;
        fixed_rx  = 8'h3C;
        start_chk = 1'b1;
        run_round("single");
        start_chk = 1'b0;
        fixed_rx  = -1;

        // Three-byte burst on requester 1
        prep(1, 3, 3);
        txq[1][0] = 8'h11;
        txq[1][1] = 8'h22;
        txq[1][2] = 8'h33;
        run_round("burst");

        // Contention from reset, then again after the pointer wraps
        do_reset();
        prep(0, 1, 1);
        prep(1, 1, 1);
        run_round("contend1");
        check_val("contend1_first", first_grant, 1);
        prep(0, 1, 1);
        prep(1, 1, 1);
        run_round("contend2");
        check_val("contend2_first", first_grant, 1);

        // Requester drops after the first ack of a four-byte burst
        prep(0, 4, 1);
        fixed_lat = 2;
        run_round("abort");
        fixed_lat = 0;

        // Master done pulse while idle is ignored
        rx_hold     = rx_data_o;
        m_done_i    = 1'b1;
        m_rx_byte_i = ~rx_hold;
        @(posedge sysClk);
        #1;
        m_done_i = 1'b0;
        check_val("idle_done_busy", busy_o, 0);
        @(posedge sysClk);
        #1;
        check_val("idle_done_ack", byte_ack_o, 0);
        check_val("idle_done_rx", rx_data_o, rx_hold);

        // Randomized traffic
        for (int r = 0; r < 15; r++) begin
            int mask;
            int n;
            mask = int'($urandom_range(1, 3));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (mask[i]) begin
                    n = int'($urandom_range(1, 4));
                    prep(i, n, (n > 1 && ($urandom % 4) == 0) ? int'($urandom_range(1, n - 1)) : n);
                end
            end
            run_round("random");
        end

        // Reset asserted in the middle of a transfer
        prep(0, 3, 3);
        drive_inputs();
        for (int k = 0; k < 50 && !m_tx_en_o; k++) begin
            @(posedge sysClk);
            #1;
        end
        check_val("midrst_reached_xfer", m_tx_en_o, 1);
        @(posedge sysClk);
        @(negedge sysClk);
        Rst_i_n = 1'b0;
        #1;
        check_val("midrst_cs_n", cs_n_o, 1);
        check_val("midrst_grant", grant_o, 0);
        check_val("midrst_busy", busy_o, 0);
        do_reset();
        prep(0, 1, 1);
        prep(1, 1, 1);
        run_round("after_rst");
        check_val("after_rst_first", first_grant, 1);

`ifdef SPI_ARB_TIMEOUT_EN
        // Master never answers; watchdog must abort the byte
        no_resp = 1'b1;
        prep(0, 1, 1);
        run_round("timeout");
        no_resp = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_bus_arbiter
`default_nettype wire

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Sequences and shares the single SPIMaster byte engine among `NUM_REQ` requesters on the system clock. Grants one requester at a time using round-robin arbitration, frames the transaction with chip-select setup and hold, and feeds bytes to the master one at a time. It returns each received byte to the granted requester and releases the bus after that requester's last byte.

## Interface
- `NUM_REQ`, 2: number of requesters (≥2).
- `CS_SETUP_CYC`, 2: sysClk cycles from `cs_n_o` falling to the first `m_tx_en_o` (≥1).
- `CS_HOLD_CYC`, 2: sysClk cycles from the last byte's `m_done_i` to `cs_n_o` rising (≥1).
- `TIMEOUT_CYC`, 1024: byte watchdog limit; used only when `SPI_ARB_TIMEOUT_EN` is defined.

Ports:
- `sysClk` in 1: the one system clock; all logic is rising-edge.
- `Rst_i_n` in 1: reset, asynchronous and active-low.
- `req_i` in NUM_REQ: per-requester transaction request (level).
- `last_i` in NUM_REQ: the presented byte is the final byte of the transaction.
- `tx_data_i` in NUM_REQ×8: per-requester byte to send.
- `grant_o` out NUM_REQ: one-hot grant, or all zero.
- `byte_ack_o` out 1: one-cycle pulse meaning the byte was sent and `rx_data_o` is valid.
- `rx_data_o` out 8: last received byte, held until the next ack.
- `busy_o` out 1: high in every state except IDLE.
- `err_o` out 1: one-cycle pulse on a timeout abort. Tied 0 without the macro.
- `cs_n_o` out 1: chip select to the slave, active low.
- `m_tx_en_o` out 1: one-cycle start pulse to SPIMaster.
- `m_tx_byte_o` out 8: byte to SPIMaster, stable from the `m_tx_en_o` pulse until `m_done_i`.
- `m_done_i` in 1: SPIMaster byte-complete pulse.
- `m_rx_byte_i` in 8: SPIMaster received byte, valid when `m_done_i` is high.

## Operation
- **Reset values:** `grant_o`=0, `cs_n_o`=1, `m_tx_en_o`=0, `m_tx_byte_o`=0, `byte_ack_o`=0, `rx_data_o`=0, `busy_o`=0, `err_o`=0. The round-robin pointer is 0 and the state is IDLE.
- **FSM states:** IDLE, ARB, CS_SETUP, LOAD, XFER, CS_HOLD.
- **IDLE:** if any `req_i` bit is high, go to ARB.
- **ARB:** pick the first requesting index at or after the pointer, wrapping modulo NUM_REQ.
  - Register the one-hot `grant_o` and drive `cs_n_o`=0.
  - Set the pointer to grant+1, wrapping.
  - Go to CS_SETUP.
  - If all requests have dropped by ARB, return to IDLE with no grant.
- **CS_SETUP:** count CS_SETUP_CYC cycles, then go to LOAD.
- **LOAD:** if `req_i[g]`=0, abort and go to CS_HOLD without sending. Otherwise:
  - Latch `tx_data_i[g]` into `m_tx_byte_o` and `last_i[g]` into an internal flag.
  - Pulse `m_tx_en_o` and go to XFER.
- **XFER:** on `m_done_i`, register `rx_data_o`<=`m_rx_byte_i` and pulse `byte_ack_o` in the next cycle.
  - Go to CS_HOLD if the latched last flag is set, otherwise back to LOAD.
  - `req_i[g]` falling during XFER has no effect; the current byte completes.
- **CS_HOLD:** count CS_HOLD_CYC cycles, then drive `cs_n_o`=1 and `grant_o`=0, and go to IDLE.
  - IDLE lasts at least 1 cycle, so `cs_n_o` stays high for at least 1 cycle between transactions.
- **Requester contract:**
  - Update `tx_data_i`/`last_i` at the edge that ends the `byte_ack_o` cycle.
  - Those values are sampled in the immediately following LOAD.
- **Boundaries:**
  - Simultaneous requests resolve by the pointer, so after reset req0 wins.
  - `m_done_i` outside XFER is ignored.
  - `Rst_i_n` low mid-transaction immediately forces all reset values, including `cs_n_o`=1.

## Timing
- `req_i` sampled high at edge k (IDLE) → `grant_o`/`cs_n_o` change after edge k+1.
- First `m_tx_en_o` pulse: CS_SETUP_CYC+1 cycles after `cs_n_o` falls.
- `m_done_i` at edge d → `byte_ack_o` high in cycle d+1. The next `m_tx_en_o` (non-last byte) is high one cycle after `byte_ack_o`.
- Last `m_done_i` → `cs_n_o` rises CS_HOLD_CYC cycles later, in the same cycle `grant_o` clears.
- Counters are `$clog2(max+1)` bits wide and saturate-free; they reload on state entry.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A watchdog counts cycles in XFER and resets on entering XFER.
  - Reaching TIMEOUT_CYC without `m_done_i` pulses `err_o` for 1 cycle, with no `byte_ack_o`, and goes to CS_HOLD.
- Not defined: no watchdog, `err_o` is constant 0, and XFER waits indefinitely.

## Structure
- Package `spi_arb_pkg`: state enum `arb_state_t`, and default setup/hold/timeout constants.
- Sub-module `rr_arbiter`: combinational round-robin pick from `req` and the pointer, giving the one-hot grant and a valid flag.
- The top FSM owns the pointer register, counters and datapath registers.

## Test plan
- **Single 1-byte transfer:** req0=1, last0=1, tx=0xA5, master returns 0x3C → one `m_tx_en_o` with byte 0xA5; `byte_ack_o` with `rx_data_o`=0x3C; `cs_n_o` low for exactly setup+1+xfer+hold cycles.
- **3-byte burst:** req1 with 0x11, 0x22, 0x33 (last on the third) → three `m_tx_en_o` pulses in order, three acks, and `cs_n_o` stays low throughout.
- **Contention:** req0 and req1 both high from reset → grant 0b01 first, then 0b10. Then re-requesting both → grant 0b01 again, because the pointer wrapped.
- **Abort:** req0 drops after the first ack of a 4-byte burst → no further `m_tx_en_o`; CS_HOLD runs, then `cs_n_o`=1.
- **Reset mid-XFER:** assert `Rst_i_n`=0 → `cs_n_o`=1 and `grant_o`=0 immediately. After release, the FSM is IDLE and the pointer is 0.
- **Timeout:** with `SPI_ARB_TIMEOUT_EN` and TIMEOUT_CYC=16, never pulse `m_done_i` → `err_o` pulses 16 cycles after `m_tx_en_o`, with no `byte_ack_o`.
